mips32_prog_loader: RTL and testbench

- Instruction encoder and loader: the write-side counterpart of the pipeline's fetch/decode path.
- Accepts decoded instruction fields over a valid/ready stream and packs them into the 32-bit MIPS32 format the pipeline decodes.
- Writes each packed word sequentially into the shared 1024x32 Memory through a single write port.
- Holds the processor off (cpu_hold) until a complete program ending in HLT has been written.

---
 rtl/mips32_prog_loader.sv | 197 +++++++++++++++++++
 tb/tb_mips32_prog_loader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_prog_loader.sv
// Packs decoded MIPS32 instruction fields into 32-bit words and loads them into program memory.
// Optional running XOR checksum of written words is enabled by defining LOADER_CHECKSUM_EN.
module mips32_prog_loader #(
  parameter int ADDR_W     = 10,
  parameter int DEPTH      = 1024,
  parameter int START_ADDR = 0
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_opcode,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_opcode,
  output logic              err_full,
  output logic [ADDR_W:0]   word_count,
  output logic              cpu_hold,
  output logic [31:0]       checksum
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

  localparam logic [5:0] OpAdd   = 6'b000000;
  localparam logic [5:0] OpSub   = 6'b000001;
  localparam logic [5:0] OpAnd   = 6'b000010;
  localparam logic [5:0] OpOr    = 6'b000011;
  localparam logic [5:0] OpSlt   = 6'b000100;
  localparam logic [5:0] OpMul   = 6'b000101;
  localparam logic [5:0] OpLw    = 6'b001000;
  localparam logic [5:0] OpSw    = 6'b001001;
  localparam logic [5:0] OpAddi  = 6'b001010;
  localparam logic [5:0] OpSubi  = 6'b001011;
  localparam logic [5:0] OpSlti  = 6'b001100;
  localparam logic [5:0] OpBneqz = 6'b001101;
  localparam logic [5:0] OpBeqz  = 6'b001110;
  localparam logic [5:0] OpHlt   = 6'b111111;

  localparam logic [ADDR_W-1:0] FirstAddr = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                errOp_q, errOp_d;
  logic                errFull_q, errFull_d;

  logic [31:0] encWord;
  logic        encLegal;
  logic        encHlt;
  logic        xfer;
  logic        startOk;

  assign xfer    = in_valid && (state_q == LOAD);
  assign startOk = start && (state_q != LOAD);

  // Encoder: unused fields of each class are forced to zero
  always_comb begin
    encWord  = 32'h0;
    encLegal = 1'b0;
    encHlt   = 1'b0;
    case (in_opcode)
      OpAdd, OpSub, OpAnd, OpOr, OpSlt, OpMul: begin
        encWord  = {in_opcode, in_rs, in_rt, in_rd, 11'b0};
        encLegal = 1'b1;
      end
      OpLw, OpSw, OpAddi, OpSubi, OpSlti: begin
        encWord  = {in_opcode, in_rs, in_rt, in_imm};
        encLegal = 1'b1;
      end
      OpBneqz, OpBeqz: begin
        encWord  = {in_opcode, in_rs, 5'b0, in_imm};
        encLegal = 1'b1;
      end
      OpHlt: begin
        encWord  = 32'hFC00_0000;
        encLegal = 1'b1;
        encHlt   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    count_d   = count_q;
    we_d      = 1'b0;
    maddr_d   = maddr_q;
    wdata_d   = wdata_q;
    errOp_d   = errOp_q;
    errFull_d = errFull_q;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (startOk) begin
          state_d   = LOAD;
          addr_d    = FirstAddr;
          count_d   = '0;
          errOp_d   = 1'b0;
          errFull_d = 1'b0;
        end
      end
      LOAD: begin
        if (xfer) begin
          if (!encLegal) begin
            errOp_d = 1'b1;
            state_d = ERR;
          end else begin
            we_d    = 1'b1;
            maddr_d = addr_q;
            wdata_d = encWord;
            addr_d  = addr_q + ADDR_W'(1);
            count_d = count_q + (ADDR_W + 1)'(1);
            // HLT on the last word is still a clean finish
            if (encHlt) begin
              state_d = DONE;
            end else if (addr_q == LastAddr) begin
              errFull_d = 1'b1;
              state_d   = ERR;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= FirstAddr;
      count_q   <= '0;
      we_q      <= 1'b0;
      maddr_q   <= '0;
      wdata_q   <= 32'h0;
      errOp_q   <= 1'b0;
      errFull_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      we_q      <= we_d;
      maddr_q   <= maddr_d;
      wdata_q   <= wdata_d;
      errOp_q   <= errOp_d;
      errFull_q <= errFull_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] cksum_q, cksum_d;

  always_comb begin
    cksum_d = cksum_q;
    if (startOk) begin
      cksum_d = 32'h0;
    end else if (xfer && encLegal) begin
      cksum_d = cksum_q ^ encWord;
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      cksum_q <= 32'h0;
    end else begin
      cksum_q <= cksum_d;
    end
  end

  assign checksum = cksum_q;
`else
  assign checksum = 32'h0;
`endif

  assign in_ready   = (state_q == LOAD);
  assign busy       = (state_q == LOAD);
  assign done       = (state_q == DONE);
  assign cpu_hold   = (state_q != DONE);
  assign mem_we     = we_q;
  assign mem_addr   = maddr_q;
  assign mem_wdata  = wdata_q;
  assign word_count = count_q;
  assign err_opcode = errOp_q;
  assign err_full   = errFull_q;

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Directed bench for mips32_prog_loader: a full-size instance and a DEPTH=4 instance for the full-memory case.
module tb_mips32_prog_loader;

  logic        clk1 = 1'b0;
  logic        rst;
  logic        start, startS;
  logic        inValid, inValidS;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;

  logic        inReady, memWe, busy, done, errOpcode, errFull, cpuHold;
  logic [9:0]  memAddr;
  logic [31:0] memWdata, checksum;
  logic [10:0] wordCount;

  logic        inReadyS, memWeS, busyS, doneS, errOpcodeS, errFullS, cpuHoldS;
  logic [9:0]  memAddrS;
  logic [31:0] memWdataS, checksumS;
  logic [10:0] wordCountS;

  int vectors = 0;
  int miscompares = 0;

`ifdef LOADER_CHECKSUM_EN
  localparam logic [31:0] CkA = 32'hD423_180A;
  localparam logic [31:0] CkB = 32'hFC22_1800;
`else
  localparam logic [31:0] CkA = 32'h0;
  localparam logic [31:0] CkB = 32'h0;
`endif

  localparam logic [5:0] ADD  = 6'b000000;
  localparam logic [5:0] MUL  = 6'b000101;
  localparam logic [5:0] SW   = 6'b001001;
  localparam logic [5:0] ADDI = 6'b001010;
  localparam logic [5:0] BEQZ = 6'b001110;
  localparam logic [5:0] HLT  = 6'b111111;
  localparam logic [5:0] BAD  = 6'b010000;

  always #5 clk1 = ~clk1;

  mips32_prog_loader dut (
    .clk1(clk1), .rst(rst), .start(start), .in_valid(inValid), .in_ready(inReady),
    .in_opcode(opcode), .in_rs(rs), .in_rt(rt), .in_rd(rd), .in_imm(imm),
    .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata), .busy(busy), .done(done),
    .err_opcode(errOpcode), .err_full(errFull), .word_count(wordCount),
    .cpu_hold(cpuHold), .checksum(checksum)
  );

  mips32_prog_loader #(.ADDR_W(10), .DEPTH(4), .START_ADDR(0)) dutS (
    .clk1(clk1), .rst(rst), .start(startS), .in_valid(inValidS), .in_ready(inReadyS),
    .in_opcode(opcode), .in_rs(rs), .in_rt(rt), .in_rd(rd), .in_imm(imm),
    .mem_we(memWeS), .mem_addr(memAddrS), .mem_wdata(memWdataS), .busy(busyS), .done(doneS),
    .err_opcode(errOpcodeS), .err_full(errFullS), .word_count(wordCountS),
    .cpu_hold(cpuHoldS), .checksum(checksumS)
  );

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                               input logic [4:0] d, input logic [15:0] i);
    opcode = op;
    rs     = s;
    rt     = t;
    rd     = d;
    imm    = i;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; startS = 1'b0; inValid = 1'b0; inValidS = 1'b0;
    applyStimulus(6'b0, 5'b0, 5'b0, 5'b0, 16'b0);
    tick();
    tick();
    checkOutput("rst_we", 32'(memWe), 32'd0);
    checkOutput("rst_hold", 32'(cpuHold), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ready", 32'(inReady), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_errs", 32'({errOpcode, errFull}), 32'd0);
    checkOutput("rst_count", 32'(wordCount), 32'd0);
    checkOutput("rst_addr", 32'(memAddr), 32'd0);
    checkOutput("rst_wdata", memWdata, 32'd0);
    checkOutput("rst_cksum", checksum, 32'd0);
    checkOutput("rst_holdS", 32'(cpuHoldS), 32'd1);

    // Session A: ADDI, ignored start, then ADD + HLT back-to-back
    rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("a_ready", 32'(inReady), 32'd1);
    checkOutput("a_busy", 32'(busy), 32'd1);
    applyStimulus(ADDI, 5'd0, 5'd1, 5'd7, 16'd10);
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    checkOutput("addi_we", 32'(memWe), 32'd1);
    checkOutput("addi_addr", 32'(memAddr), 32'd0);
    checkOutput("addi_word", memWdata, 32'h2801_000A);
    checkOutput("addi_count", 32'(wordCount), 32'd1);
    tick();
    checkOutput("idle_we", 32'(memWe), 32'd0);
    checkOutput("hold_addr", 32'(memAddr), 32'd0);
    checkOutput("hold_word", memWdata, 32'h2801_000A);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("ign_start_busy", 32'(busy), 32'd1);
    checkOutput("ign_start_count", 32'(wordCount), 32'd1);
    applyStimulus(ADD, 5'd1, 5'd2, 5'd3, 16'hFFFF);
    inValid = 1'b1;
    tick();
    checkOutput("add_we", 32'(memWe), 32'd1);
    checkOutput("add_addr", 32'(memAddr), 32'd1);
    checkOutput("add_word", memWdata, 32'h0022_1800);
    checkOutput("add_count", 32'(wordCount), 32'd2);
    applyStimulus(HLT, 5'd5, 5'd6, 5'd7, 16'h1234);
    tick();
    inValid = 1'b0;
    checkOutput("hlt_we", 32'(memWe), 32'd1);
    checkOutput("hlt_addr", 32'(memAddr), 32'd2);
    checkOutput("hlt_word", memWdata, 32'hFC00_0000);
    checkOutput("hlt_done", 32'(done), 32'd1);
    checkOutput("hlt_hold", 32'(cpuHold), 32'd0);
    checkOutput("hlt_busy", 32'(busy), 32'd0);
    checkOutput("hlt_ready", 32'(inReady), 32'd0);
    checkOutput("hlt_count", 32'(wordCount), 32'd3);
    checkOutput("a_cksum", checksum, CkA);
    applyStimulus(ADD, 5'd1, 5'd2, 5'd3, 16'h0);
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    checkOutput("done_nowrite", 32'(memWe), 32'd0);
    checkOutput("done_count", 32'(wordCount), 32'd3);
    checkOutput("done_sticky", 32'(done), 32'd1);

    // Session B: restart after DONE clears state and rewrites from address 0
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("b_count", 32'(wordCount), 32'd0);
    checkOutput("b_done", 32'(done), 32'd0);
    checkOutput("b_hold", 32'(cpuHold), 32'd1);
    checkOutput("b_cksum0", checksum, 32'd0);
    applyStimulus(ADD, 5'd1, 5'd2, 5'd3, 16'h0);
    inValid = 1'b1;
    tick();
    checkOutput("b_add_addr", 32'(memAddr), 32'd0);
    checkOutput("b_add_word", memWdata, 32'h0022_1800);
    applyStimulus(HLT, 5'd0, 5'd0, 5'd0, 16'h0);
    tick();
    inValid = 1'b0;
    checkOutput("b_hlt_addr", 32'(memAddr), 32'd1);
    checkOutput("b_hlt_word", memWdata, 32'hFC00_0000);
    checkOutput("b_done", 32'(done), 32'd1);
    checkOutput("b_hold", 32'(cpuHold), 32'd0);
    checkOutput("b_ready", 32'(inReady), 32'd0);
    checkOutput("b_count2", 32'(wordCount), 32'd2);
    checkOutput("b_cksum", checksum, CkB);

    // Session C: illegal opcode as second tuple
    start = 1'b1;
    tick();
    start = 1'b0;
    applyStimulus(ADD, 5'd1, 5'd2, 5'd3, 16'h0);
    inValid = 1'b1;
    tick();
    checkOutput("c_add_we", 32'(memWe), 32'd1);
    checkOutput("c_add_addr", 32'(memAddr), 32'd0);
    applyStimulus(BAD, 5'd1, 5'd2, 5'd3, 16'h5555);
    tick();
    inValid = 1'b0;
    checkOutput("bad_we", 32'(memWe), 32'd0);
    checkOutput("bad_err", 32'(errOpcode), 32'd1);
    checkOutput("bad_busy", 32'(busy), 32'd0);
    checkOutput("bad_ready", 32'(inReady), 32'd0);
    checkOutput("bad_count", 32'(wordCount), 32'd1);
    checkOutput("bad_hold", 32'(cpuHold), 32'd1);
    checkOutput("bad_done", 32'(done), 32'd0);
    tick();
    checkOutput("bad_sticky", 32'(errOpcode), 32'd1);

    // Session D: SW, BEQZ and MUL encodings, then reset mid-session
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("d_err_clr", 32'(errOpcode), 32'd0);
    applyStimulus(SW, 5'd3, 5'd4, 5'd9, 16'h8001);
    inValid = 1'b1;
    tick();
    checkOutput("sw_word", memWdata, 32'h2464_8001);
    applyStimulus(BEQZ, 5'd5, 5'd7, 5'd9, 16'h0010);
    tick();
    checkOutput("beqz_word", memWdata, 32'h38A0_0010);
    checkOutput("beqz_addr", 32'(memAddr), 32'd1);
    applyStimulus(MUL, 5'd31, 5'd31, 5'd31, 16'hFFFF);
    tick();
    inValid = 1'b0;
    checkOutput("mul_word", memWdata, 32'h17FF_F800);
    checkOutput("mul_addr", 32'(memAddr), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mid_rst_we", 32'(memWe), 32'd0);
    checkOutput("mid_rst_hold", 32'(cpuHold), 32'd1);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_count", 32'(wordCount), 32'd0);
    checkOutput("mid_rst_addr", 32'(memAddr), 32'd0);
    checkOutput("mid_rst_word", memWdata, 32'd0);
    checkOutput("mid_rst_cksum", checksum, 32'd0);

    // Small instance: fill all four words without HLT
    startS = 1'b1;
    tick();
    startS = 1'b0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(ADD, 5'd1, 5'd2, 5'(k), 16'h0);
      inValidS = 1'b1;
      tick();
      checkOutput("full_we", 32'(memWeS), 32'd1);
      checkOutput("full_addr", 32'(memAddrS), 32'(k));
      checkOutput("full_word", memWdataS, 32'h0022_0000 | (32'(k) << 11));
      checkOutput("full_flag", 32'(errFullS), (k == 3) ? 32'd1 : 32'd0);
    end
    inValidS = 1'b0;
    checkOutput("full_ready", 32'(inReadyS), 32'd0);
    checkOutput("full_busy", 32'(busyS), 32'd0);
    tick();
    checkOutput("full_sticky", 32'(errFullS), 32'd1);
    checkOutput("full_we_off", 32'(memWeS), 32'd0);
    checkOutput("full_count", 32'(wordCountS), 32'd4);

    // Small instance: HLT in the last word is a normal finish
    startS = 1'b1;
    tick();
    startS = 1'b0;
    checkOutput("last_err_clr", 32'(errFullS), 32'd0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus((k == 3) ? HLT : ADD, 5'd1, 5'd2, 5'(k), 16'h0);
      inValidS = 1'b1;
      tick();
    end
    inValidS = 1'b0;
    checkOutput("last_addr", 32'(memAddrS), 32'd3);
    checkOutput("last_word", memWdataS, 32'hFC00_0000);
    checkOutput("last_done", 32'(doneS), 32'd1);
    checkOutput("last_err", 32'(errFullS), 32'd0);
    checkOutput("last_count", 32'(wordCountS), 32'd4);
    checkOutput("last_cksum", checksumS, CkB);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
